// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock core: mode encoding,
// field widths, alarm reset default and the snooze-target arithmetic.
package alarm_clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int MODE_W = 3;

    localparam logic [HOUR_W-1:0] AL_HOUR_RST = 5'd6;
    localparam logic [MIN_W-1:0]  AL_MIN_RST  = 6'd0;

    typedef enum logic [MODE_W-1:0] {
        RUN      = 3'd0,
        SET_HOUR = 3'd1,
        SET_MIN  = 3'd2,
        AL_HOUR  = 3'd3,
        AL_MIN   = 3'd4
    } mode_t;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
    } hm_t;

    // hour:min + delta minutes (delta < 60), wrapping past 23:59.
    function automatic hm_t add_minutes(input logic [HOUR_W-1:0] hour,
                                        input logic [MIN_W-1:0]  min,
                                        input logic [MIN_W-1:0]  delta);
        hm_t            res;
        logic [MIN_W:0] msum;
        msum     = {1'b0, min} + {1'b0, delta};
        res.hour = hour;
        res.min  = msum[MIN_W-1:0];
        if (msum >= 7'd60) begin
            res.min = msum[MIN_W-1:0] - 6'd60;
            if (hour == 5'd23) begin
                res.hour = 5'd0;
            end else begin
                res.hour = hour + 5'd1;
            end
        end else begin
            res.min = msum[MIN_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with clear and hold; carry pulses when an
// increment wraps MODULUS-1 back to zero.
module mod_counter #(
    parameter int           MODULUS = 60,
    parameter int           W       = 6,
    parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] MAX_VAL = W'(MODULUS - 1);
    localparam logic [W-1:0] ZERO    = {W{1'b0}};
    localparam logic [W-1:0] ONE     = W'(1);

    logic [W-1:0] value_r;

    assign carry = inc && !clear && (value_r == MAX_VAL);
    assign value = value_r;

    // Clear beats increment beats decrement; both directions wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_r <= RST_VAL;
        end else if (clear) begin
            value_r <= ZERO;
        end else if (inc) begin
            value_r <= (value_r == MAX_VAL) ? ZERO : value_r + ONE;
        end else if (dec) begin
            value_r <= (value_r == ZERO) ? MAX_VAL : value_r - ONE;
        end else begin
            value_r <= value_r;
        end
    end

endmodule

// File: rtl/alarm_clock_core.sv
// Time-keeping and alarm core: prescaled seconds chain, button-driven
// time/alarm setting FSM, and ring control with snooze and auto-timeout.
module alarm_clock_core
    import alarm_clock_pkg::*;
#(
    parameter int TICK_DIV   = 10_000_000,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up_pulse,
    input  logic              down_pulse,
    input  logic              center_pulse,
    input  logic              alarm_en,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  min,
    output logic [SEC_W-1:0]  sec,
    output logic [HOUR_W-1:0] al_hour,
    output logic [MIN_W-1:0]  al_min,
    output logic [MODE_W-1:0] mode,
    output logic              ringing,
    output logic              blink
);

    localparam int               PRE_W        = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX      = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_HALF     = PRE_W'(TICK_DIV / 2);
    localparam logic [PRE_W-1:0] PRE_ZERO     = {PRE_W{1'b0}};
    localparam logic [PRE_W-1:0] PRE_ONE      = PRE_W'(1);
    localparam logic [MIN_W-1:0] SNOOZE_DELTA = MIN_W'(SNOOZE_MIN);
    localparam logic [8:0]       RING_LIMIT   = 9'(RING_SEC);

    mode_t             mode_r;
    mode_t             mode_nxt_s;
    logic [PRE_W-1:0]  prescaler_r;
    logic [PRE_W-1:0]  prescaler_nxt_s;
    logic              blink_r;
    logic              new_sec_r;
    logic              tick_s;
    logic              set_mode_s;

    logic              in_set_hour_s, in_set_min_s, in_al_hour_s, in_al_min_s;
    logic              center_ok_s, up_s, dn_s;
    logic              sec_clr_s, min_inc_s, min_dec_s, hour_inc_s, hour_dec_s;
    logic              alh_inc_s, alh_dec_s, alm_inc_s, alm_dec_s;
    logic              sec_carry_s, min_carry_s;
    logic              unused_hour_carry_s, unused_alh_carry_s, unused_alm_carry_s;

    logic              ringing_r;
    logic [7:0]        ring_cnt_r;
    logic [8:0]        ring_cnt_inc_s;
    logic              snz_pend_r;
    logic [HOUR_W-1:0] snz_hour_r;
    logic [MIN_W-1:0]  snz_min_r;
    hm_t               snz_target_s;
    logic              al_match_s, snz_match_s, trigger_s;

    assign set_mode_s    = (mode_r == SET_HOUR) || (mode_r == SET_MIN);
    assign in_set_hour_s = (mode_r == SET_HOUR);
    assign in_set_min_s  = (mode_r == SET_MIN);
    assign in_al_hour_s  = (mode_r == AL_HOUR);
    assign in_al_min_s   = (mode_r == AL_MIN);
    assign tick_s        = !set_mode_s && (prescaler_r == PRE_MAX);

    // Buttons are swallowed while ringing; center outranks up, up outranks down.
    assign center_ok_s = !ringing_r && center_pulse;
    assign up_s        = !ringing_r && !center_pulse && up_pulse;
    assign dn_s        = !ringing_r && !center_pulse && !up_pulse && down_pulse;

    // Set modes never tick, so an edit wrap cannot leak into the next field.
    assign sec_clr_s  = in_set_min_s && center_ok_s;
    assign min_inc_s  = sec_carry_s || (in_set_min_s && up_s);
    assign min_dec_s  = in_set_min_s && dn_s;
    assign hour_inc_s = (sec_carry_s && min_carry_s) || (in_set_hour_s && up_s);
    assign hour_dec_s = in_set_hour_s && dn_s;
    assign alh_inc_s  = in_al_hour_s && up_s;
    assign alh_dec_s  = in_al_hour_s && dn_s;
    assign alm_inc_s  = in_al_min_s && up_s;
    assign alm_dec_s  = in_al_min_s && dn_s;

    mod_counter #(.MODULUS(60), .W(SEC_W), .RST_VAL(6'd0)) u_sec (
        .clk(clk), .reset(reset), .clear(sec_clr_s), .inc(tick_s), .dec(1'b0),
        .value(sec), .carry(sec_carry_s)
    );

    mod_counter #(.MODULUS(60), .W(MIN_W), .RST_VAL(6'd0)) u_min (
        .clk(clk), .reset(reset), .clear(1'b0), .inc(min_inc_s), .dec(min_dec_s),
        .value(min), .carry(min_carry_s)
    );

    mod_counter #(.MODULUS(24), .W(HOUR_W), .RST_VAL(5'd0)) u_hour (
        .clk(clk), .reset(reset), .clear(1'b0), .inc(hour_inc_s), .dec(hour_dec_s),
        .value(hour), .carry(unused_hour_carry_s)
    );

    mod_counter #(.MODULUS(24), .W(HOUR_W), .RST_VAL(AL_HOUR_RST)) u_al_hour (
        .clk(clk), .reset(reset), .clear(1'b0), .inc(alh_inc_s), .dec(alh_dec_s),
        .value(al_hour), .carry(unused_alh_carry_s)
    );

    mod_counter #(.MODULUS(60), .W(MIN_W), .RST_VAL(AL_MIN_RST)) u_al_min (
        .clk(clk), .reset(reset), .clear(1'b0), .inc(alm_inc_s), .dec(alm_dec_s),
        .value(al_min), .carry(unused_alm_carry_s)
    );

    // Prescaler wraps at TICK_DIV-1 and is pinned to zero while setting time.
    always_comb begin
        prescaler_nxt_s = prescaler_r;
        if (set_mode_s) begin
            prescaler_nxt_s = PRE_ZERO;
        end else if (prescaler_r == PRE_MAX) begin
            prescaler_nxt_s = PRE_ZERO;
        end else begin
            prescaler_nxt_s = prescaler_r + PRE_ONE;
        end
    end

    // Mode sequence advanced by center; frozen while the alarm rings.
    always_comb begin
        mode_nxt_s = mode_r;
        if (center_ok_s) begin
            case (mode_r)
                RUN:      mode_nxt_s = SET_HOUR;
                SET_HOUR: mode_nxt_s = SET_MIN;
                SET_MIN:  mode_nxt_s = AL_HOUR;
                AL_HOUR:  mode_nxt_s = AL_MIN;
                AL_MIN:   mode_nxt_s = RUN;
                default:  mode_nxt_s = RUN;
            endcase
        end else begin
            mode_nxt_s = mode_r;
        end
    end

    // Timebase, blink phase, one-cycle-delayed tick and mode register.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_r <= PRE_ZERO;
            blink_r     <= 1'b1;
            new_sec_r   <= 1'b0;
            mode_r      <= RUN;
        end else begin
            prescaler_r <= prescaler_nxt_s;
            blink_r     <= (prescaler_nxt_s < PRE_HALF);
            new_sec_r   <= tick_s;
            mode_r      <= mode_nxt_s;
        end
    end

    // Compare runs the cycle after a tick so only fresh :00 seconds trigger.
    assign al_match_s     = (hour == al_hour) && (min == al_min);
    assign snz_match_s    = snz_pend_r && (hour == snz_hour_r) && (min == snz_min_r);
    assign trigger_s      = alarm_en && new_sec_r && (sec == 6'd0) && !set_mode_s &&
                            (al_match_s || snz_match_s);
    assign ring_cnt_inc_s = {1'b0, ring_cnt_r} + 9'd1;
    assign snz_target_s   = add_minutes(hour, min, SNOOZE_DELTA);

    // Ring state: disable, dismiss, snooze, trigger, then timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            ringing_r  <= 1'b0;
            ring_cnt_r <= 8'd0;
            snz_pend_r <= 1'b0;
            snz_hour_r <= 5'd0;
            snz_min_r  <= 6'd0;
        end else if (!alarm_en) begin
            ringing_r  <= 1'b0;
            snz_pend_r <= 1'b0;
        end else if (ringing_r && center_pulse) begin
            ringing_r  <= 1'b0;
            snz_pend_r <= 1'b0;
        end else if (ringing_r && (up_pulse || down_pulse)) begin
            ringing_r  <= 1'b0;
            snz_pend_r <= 1'b1;
            snz_hour_r <= snz_target_s.hour;
            snz_min_r  <= snz_target_s.min;
        end else if (trigger_s) begin
            ringing_r  <= 1'b1;
            ring_cnt_r <= 8'd0;
            snz_pend_r <= snz_pend_r && !snz_match_s;
        end else if (ringing_r && new_sec_r) begin
            ring_cnt_r <= ring_cnt_inc_s[7:0];
            ringing_r  <= (ring_cnt_inc_s != RING_LIMIT);
        end else begin
            ringing_r  <= ringing_r;
        end
    end

    assign mode    = mode_r;
    assign ringing = ringing_r;
    assign blink   = blink_r;

endmodule
